// File: rtl/exp_sigma_pkg.sv
// Shared widths, FSM state encoding and default job limits for the
// CalculateExpSigma scheduler.
`timescale 1ns/1ps
package exp_sigma_pkg;
   localparam int SIGMA_W     = 18;
   localparam int DATA_W      = 17;
   localparam int ADDR_W      = 6;
   localparam int BANK_W      = 1;
   localparam int ENTRIES_DEF = 64;
   localparam int TIMEOUT_DEF = 4095;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_t;

   function automatic logic [1:0] bank_mask(input logic bank);
      return bank ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last winner.
// The pointer only moves when the caller accepts the grant.
`timescale 1ns/1ps
module rr_arbiter #(
   parameter  int NREQ  = 2,
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic             en,
   input  logic             advance,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx
);
   localparam int SW = IDX_W + 1;

   logic [IDX_W-1:0] ptr;
   logic [SW-1:0]    raw;
   logic [SW-1:0]    wrapped;
   logic [IDX_W-1:0] cand;
   logic             found;

   // first requesting index at or after ptr, wrapping modulo NREQ
   always_comb begin
      gnt     = '0;
      idx     = '0;
      found   = 1'b0;
      raw     = '0;
      wrapped = '0;
      cand    = '0;
      if (en) begin
         for (int i = 0; i < NREQ; i++) begin
            raw     = {1'b0, ptr} + SW'(i);
            wrapped = (raw >= SW'(NREQ)) ? (raw - SW'(NREQ)) : raw;
            cand    = wrapped[IDX_W-1:0];
            if (!found && req[cand]) begin
               found     = 1'b1;
               gnt[cand] = 1'b1;
               idx       = cand;
            end else begin
               found = found;
            end
         end
      end else begin
         gnt = '0;
      end
   end

   // pointer holds the next index to favour
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
         ptr <= ptr;
      end
   end
endmodule

// File: rtl/exp_sigma_scheduler.sv
// Shares one CalculateExpSigma engine between NREQ requesters and captures
// each 64-entry result stream into one of two ping-pong table banks.
`timescale 1ns/1ps
module exp_sigma_scheduler
   import exp_sigma_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [NREQ-1:0]           iReq,
   input  logic [NREQ*SIGMA_W-1:0]   iReqSigma,
   output logic [NREQ-1:0]           oGrant,
   output logic [NREQ-1:0]           oReqDone,
   output logic                      oReqBank,
   output logic                      oErr,
   output logic [1:0]                oBankBusy,
   input  logic [1:0]                iRelease,
   output logic [SIGMA_W-1:0]        oEngSigma,
   output logic                      oEngStart,
   input  logic [DATA_W-1:0]         iEngData,
   input  logic [ADDR_W-1:0]         iEngAddr,
   input  logic                      iEngValid,
   input  logic                      iEngDone,
   output logic                      oWrEn,
   output logic [BANK_W+ADDR_W-1:0]  oWrAddr,
   output logic [DATA_W-1:0]         oWrData
);
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(ENTRIES + 1);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   state_t           state;
   logic             bank;
   logic [NREQ-1:0]  owner;
   logic [CNT_W-1:0] count;
   logic [WD_W-1:0]  wd;
   logic [NREQ-1:0]  arb_gnt;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_en;
   logic             take;
   logic             full_run;
   logic [1:0]       busy_set;
   logic [SIGMA_W-1:0] sigma_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_sigma
      assign sigma_arr[g] = iReqSigma[g*SIGMA_W +: SIGMA_W];
   end

   // lowest free bank is bank 0 unless it is busy
   assign arb_en   = (state == IDLE) && (oBankBusy != 2'b11);
   assign take     = arb_en && (|arb_gnt);
   assign full_run = (count == CNT_W'(ENTRIES));
   assign busy_set = ((state == FINISH) && full_run) ? bank_mask(bank) : 2'b00;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (CLK),
      .rst_n   (nRST),
      .req     (iReq),
      .en      (arb_en),
      .advance (take),
      .gnt     (arb_gnt),
      .idx     (arb_idx)
   );

   // job sequencing FSM with all outputs registered
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         bank      <= 1'b0;
         owner     <= '0;
         count     <= '0;
         wd        <= '0;
         oGrant    <= '0;
         oReqDone  <= '0;
         oReqBank  <= 1'b0;
         oErr      <= 1'b0;
         oBankBusy <= 2'b00;
         oEngSigma <= '0;
         oEngStart <= 1'b0;
         oWrEn     <= 1'b0;
         oWrAddr   <= '0;
         oWrData   <= '0;
      end else begin
         oGrant    <= '0;
         oReqDone  <= '0;
         oEngStart <= 1'b0;
         oWrEn     <= 1'b0;
         oBankBusy <= (oBankBusy & ~iRelease) | busy_set;
         case (state)
            IDLE: begin
               if (take) begin
                  oGrant    <= arb_gnt;
                  owner     <= arb_gnt;
                  oEngSigma <= sigma_arr[arb_idx];
                  bank      <= oBankBusy[0];
                  state     <= START;
               end else begin
                  state <= IDLE;
               end
            end
            START: begin
               oEngStart <= 1'b1;
               count     <= '0;
               wd        <= '0;
               state     <= RUN;
            end
            RUN: begin
               if (iEngValid && (count < CNT_W'(ENTRIES))) begin
                  oWrEn   <= 1'b1;
                  oWrAddr <= {bank, iEngAddr};
                  oWrData <= iEngData;
                  count   <= count + CNT_W'(1);
               end else begin
                  count <= count;
               end
               if (iEngValid || iEngDone) begin
                  wd <= '0;
               end else if (wd < WD_W'(TIMEOUT)) begin
                  wd <= wd + WD_W'(1);
               end else begin
                  wd <= wd;
               end
               // the TIMEOUT-th silent cycle aborts the job like a short run
               if (iEngDone) begin
                  state <= FINISH;
               end else if (!iEngValid && (wd >= WD_W'(TIMEOUT - 1))) begin
                  oErr  <= 1'b1;
                  state <= IDLE;
               end else begin
                  state <= RUN;
               end
            end
            FINISH: begin
               if (full_run) begin
                  oReqDone <= owner;
                  oReqBank <= bank;
               end else begin
                  oErr <= 1'b1;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_exp_sigma_scheduler.sv
// Scoreboard bench: expected grants, writes and completions are queued with
// the stimulus; a negedge monitor pops and compares whatever the DUT emits.
`timescale 1ns/1ps
module tb_exp_sigma_scheduler;
   logic        CLK;
   logic        nRST;
   logic [1:0]  iReq;
   logic [35:0] iReqSigma;
   logic [1:0]  oGrant;
   logic [1:0]  oReqDone;
   logic        oReqBank;
   logic        oErr;
   logic [1:0]  oBankBusy;
   logic [1:0]  iRelease;
   logic [17:0] oEngSigma;
   logic        oEngStart;
   logic [16:0] iEngData;
   logic [5:0]  iEngAddr;
   logic        iEngValid;
   logic        iEngDone;
   logic        oWrEn;
   logic [6:0]  oWrAddr;
   logic [16:0] oWrData;

   int checks   = 0;
   int failures = 0;
   int wr_seen  = 0;
   int gr_seen  = 0;

   logic [23:0] exp_wr[$];
   logic [19:0] exp_grant[$];
   logic [2:0]  exp_done[$];
   logic [23:0] mon_w;
   logic [19:0] mon_g;
   logic [2:0]  mon_d;

   localparam logic [17:0] S0 = 18'd6554;
   localparam logic [17:0] S1 = 18'd13107;

   exp_sigma_scheduler #(.NREQ(2), .ENTRIES(64), .TIMEOUT(15)) dut (
      .CLK(CLK), .nRST(nRST), .iReq(iReq), .iReqSigma(iReqSigma),
      .oGrant(oGrant), .oReqDone(oReqDone), .oReqBank(oReqBank), .oErr(oErr),
      .oBankBusy(oBankBusy), .iRelease(iRelease), .oEngSigma(oEngSigma),
      .oEngStart(oEngStart), .iEngData(iEngData), .iEngAddr(iEngAddr),
      .iEngValid(iEngValid), .iEngDone(iEngDone), .oWrEn(oWrEn),
      .oWrAddr(oWrAddr), .oWrData(oWrData)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // monitor: every DUT output event is matched against the head of its queue
   always @(negedge CLK) begin
      if (oWrEn) begin
         wr_seen++;
         if (exp_wr.size() == 0) begin
            checks++; failures++;
            $display("FAIL write_unexpected actual=%0h/%0h required=none", oWrAddr, oWrData);
         end else begin
            mon_w = exp_wr.pop_front();
            chk("write", {40'd0, oWrAddr, oWrData}, {40'd0, mon_w});
         end
      end
      if (oGrant != 2'b00) begin
         gr_seen++;
         if (exp_grant.size() == 0) begin
            checks++; failures++;
            $display("FAIL grant_unexpected actual=%0h required=none", oGrant);
         end else begin
            mon_g = exp_grant.pop_front();
            chk("grant_sigma", {44'd0, oGrant, oEngSigma}, {44'd0, mon_g});
         end
      end
      if (oReqDone != 2'b00) begin
         if (exp_done.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_unexpected actual=%0h required=none", oReqDone);
         end else begin
            mon_d = exp_done.pop_front();
            chk("done_bank", {61'd0, oReqDone, oReqBank}, {61'd0, mon_d});
         end
      end
   end

   task automatic wait_for(input int which, input string name);
      int  n;
      bit  hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 300) begin
         @(negedge CLK);
         n++;
         case (which)
            0:       hit = |oGrant;
            1:       hit = oEngStart;
            default: hit = |oReqDone;
         endcase
      end
      if (!hit) begin
         checks++; failures++;
         $display("FAIL wait_%s actual=timeout required=event within %0d cycles", name, n);
      end
   endtask

   task automatic engine(input int nval, input bit dwl, input logic bank, input logic [16:0] base);
      wait_for(1, "start");
      for (int i = 0; i < nval; i++) begin
         @(posedge CLK); #1;
         iEngValid = 1'b1;
         iEngAddr  = 6'(i);
         iEngData  = base + 17'(i);
         iEngDone  = dwl && (i == nval - 1);
         if (i < 64) exp_wr.push_back({bank, 6'(i), base + 17'(i)});
      end
      @(posedge CLK); #1;
      iEngValid = 1'b0;
      iEngDone  = !dwl;
      if (!dwl) begin
         @(posedge CLK); #1;
         iEngDone = 1'b0;
      end
   endtask

   task automatic release_bank(input logic [1:0] m);
      @(posedge CLK); #1;
      iRelease = m;
      @(posedge CLK); #1;
      iRelease = 2'b00;
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      nRST = 1'b0;
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      int snap;
      nRST = 1'b0; iReq = 2'b00; iReqSigma = {S1, S0}; iRelease = 2'b00;
      iEngData = '0; iEngAddr = '0; iEngValid = 1'b0; iEngDone = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_outputs", {12'd0, oGrant, oReqDone, oReqBank, oErr, oBankBusy, oEngSigma,
                            oEngStart, oWrEn, oWrAddr, oWrData}, 64'd0);
      nRST = 1'b1;

      // single job
      exp_grant.push_back({2'b01, S0});
      iReq = 2'b01;
      wait_for(0, "grant");
      iReq = 2'b00;
      exp_done.push_back({2'b01, 1'b0});
      engine(64, 1'b0, 1'b0, 17'h00100);
      wait_for(2, "done");
      chk("single_busy", {62'd0, oBankBusy}, 64'd1);
      chk("single_err", {63'd0, oErr}, 64'd0);

      // round robin with both requests held
      apply_reset();
      chk("reset_busy", {62'd0, oBankBusy}, 64'd0);
      exp_grant.push_back({2'b01, S0});
      exp_grant.push_back({2'b10, S1});
      exp_grant.push_back({2'b01, S0});
      exp_grant.push_back({2'b10, S1});
      iReq = 2'b11;
      exp_done.push_back({2'b01, 1'b0});
      engine(64, 1'b0, 1'b0, 17'h01000);
      wait_for(2, "done");
      release_bank(2'b01);
      exp_done.push_back({2'b10, 1'b1});
      engine(64, 1'b1, 1'b1, 17'h02000);
      wait_for(2, "done");
      release_bank(2'b10);
      exp_done.push_back({2'b01, 1'b0});
      engine(64, 1'b0, 1'b0, 17'h03000);
      wait_for(2, "done");
      release_bank(2'b01);
      iReq = 2'b00;
      exp_done.push_back({2'b10, 1'b1});
      engine(64, 1'b0, 1'b1, 17'h04000);
      wait_for(2, "done");
      release_bank(2'b10);
      @(negedge CLK);
      chk("rr_busy_released", {62'd0, oBankBusy}, 64'd0);

      // bank exhaustion
      exp_grant.push_back({2'b01, S0});
      iReq = 2'b01;
      wait_for(0, "grant");
      iReq = 2'b00;
      exp_done.push_back({2'b01, 1'b0});
      engine(64, 1'b0, 1'b0, 17'h05000);
      wait_for(2, "done");
      exp_grant.push_back({2'b10, S1});
      iReq = 2'b10;
      wait_for(0, "grant");
      iReq = 2'b00;
      exp_done.push_back({2'b10, 1'b1});
      engine(64, 1'b0, 1'b1, 17'h06000);
      wait_for(2, "done");
      chk("exhaust_busy", {62'd0, oBankBusy}, 64'd3);
      snap = gr_seen;
      iReq = 2'b01;
      repeat (8) @(negedge CLK);
      chk("exhaust_no_grant", 64'(gr_seen), 64'(snap));
      exp_grant.push_back({2'b01, S0});
      @(posedge CLK); #1;
      iRelease = 2'b01;
      @(negedge CLK);
      @(posedge CLK); #1;
      iRelease = 2'b00;
      @(negedge CLK);
      chk("release_grant_n1", {62'd0, oGrant}, 64'd0);
      @(negedge CLK);
      chk("release_grant_n2", {62'd0, oGrant}, 64'd1);
      iReq = 2'b00;
      exp_done.push_back({2'b01, 1'b0});
      engine(64, 1'b0, 1'b0, 17'h07000);
      wait_for(2, "done");
      chk("exhaust_busy_again", {62'd0, oBankBusy}, 64'd3);
      release_bank(2'b11);
      @(negedge CLK);
      chk("release_both", {62'd0, oBankBusy}, 64'd0);

      // short run, then the re-raised request succeeds (extra valids ignored)
      exp_grant.push_back({2'b10, S1});
      iReq = 2'b10;
      wait_for(0, "grant");
      iReq = 2'b00;
      engine(63, 1'b0, 1'b0, 17'h0A000);
      repeat (4) @(negedge CLK);
      chk("short_err", {63'd0, oErr}, 64'd1);
      chk("short_busy", {62'd0, oBankBusy}, 64'd0);
      exp_grant.push_back({2'b10, S1});
      iReq = 2'b10;
      wait_for(0, "grant");
      iReq = 2'b00;
      exp_done.push_back({2'b10, 1'b0});
      engine(66, 1'b0, 1'b0, 17'h0B000);
      wait_for(2, "done");
      chk("retry_busy", {62'd0, oBankBusy}, 64'd1);
      chk("err_sticky", {63'd0, oErr}, 64'd1);

      // watchdog abort after 15 silent RUN cycles
      apply_reset();
      chk("reset_err", {63'd0, oErr}, 64'd0);
      exp_grant.push_back({2'b01, S0});
      iReq = 2'b01;
      wait_for(0, "grant");
      iReq = 2'b00;
      wait_for(1, "start");
      repeat (14) @(negedge CLK);
      chk("timeout_not_yet", {63'd0, oErr}, 64'd0);
      @(negedge CLK);
      chk("timeout_err", {63'd0, oErr}, 64'd1);

      // reset in the middle of RUN, stale engine output afterwards
      exp_grant.push_back({2'b10, S1});
      iReq = 2'b10;
      wait_for(0, "grant");
      iReq = 2'b00;
      wait_for(1, "start");
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         iEngValid = 1'b1;
         iEngAddr  = 6'(i);
         iEngData  = 17'h0C000 + 17'(i);
         exp_wr.push_back({1'b0, 6'(i), 17'h0C000 + 17'(i)});
      end
      @(posedge CLK);
      @(negedge CLK);
      #1 nRST = 1'b0;
      #1;
      chk("async_reset_outputs", {12'd0, oGrant, oReqDone, oReqBank, oErr, oBankBusy, oEngSigma,
                                  oEngStart, oWrEn, oWrAddr, oWrData}, 64'd0);
      @(negedge CLK);
      nRST = 1'b1;
      snap = wr_seen;
      repeat (6) @(negedge CLK);
      chk("stale_valid_no_write", 64'(wr_seen), 64'(snap));
      iEngValid = 1'b0;

      chk("writes_drained", 64'(exp_wr.size()), 64'd0);
      chk("grants_drained", 64'(exp_grant.size()), 64'd0);
      chk("dones_drained", 64'(exp_done.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/exp_sigma_scheduler.md
Name: exp_sigma_scheduler

Overview:
Shares one CalculateExpSigma engine between NREQ requesters. Round-robin arbitrates the requests, latches the winner's sigma and pulses the engine start. It then captures the engine's 64-entry output stream into one of two ping-pong table banks and reports completion with the bank id. Bank-release, watchdog and error handling make the engine safe to share across the risk pipeline.

Parameters:
NREQ, 2, number of requesters (2..8)
ENTRIES, 64, entries the engine must deliver per job
TIMEOUT, 4095, max idle cycles in RUN without iEngValid/iEngDone before abort

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iReq  in  NREQ  per-requester request level; held until oGrant
iReqSigma  in  NREQ*18  per-requester sigma, slice k = bits [18k+17:18k]
oGrant  out  NREQ  one-hot one-cycle grant pulse
oReqDone  out  NREQ  one-hot one-cycle completion pulse
oReqBank  out  1  bank holding the result; valid with oReqDone
oErr  out  1  sticky error flag; cleared only by reset
oBankBusy  out  2  bank holds an unreleased result
iRelease  in  2  per-bank release pulse from consumer
oEngSigma  out  18  sigma to engine; stable from START until job end
oEngStart  out  1  one-cycle engine start pulse
iEngData  in  17  engine data
iEngAddr  in  6  engine entry address
iEngValid  in  1  engine data valid
iEngDone  in  1  engine finished
oWrEn  out  1  table write enable
oWrAddr  out  7  {bank, iEngAddr}
oWrData  out  17  registered iEngData

Behaviour:
- Reset values: all outputs 0; state IDLE; both banks free; RR pointer 0; counters 0.
- FSM states: IDLE, START, RUN, FINISH.
- IDLE:
  - Requires any iReq and at least one free bank.
  - Picks the winner round-robin, searching from last-granted+1.
  - Allocates the lowest-numbered free bank.
  - Latches the winner's sigma into oEngSigma and pulses oGrant.
  - Next state START. Latency is 1 cycle from a sampled request to the oGrant edge.
- No free bank: requests wait in IDLE; no grant is issued.
- START: oEngStart=1 for exactly one cycle; entry counter and watchdog cleared; -> RUN.
- RUN, on each iEngValid:
  - Next cycle: oWrEn=1, oWrAddr={bank,iEngAddr}, oWrData=iEngData (1-cycle write latency).
  - Entry count increments and the watchdog resets.
  - Valids arriving after the count reaches ENTRIES are ignored: no write, no count.
- RUN, on iEngDone -> FINISH. If the last iEngValid arrives in the same cycle, it is still written and counted.
- FINISH, count == ENTRIES:
  - oReqDone pulses for the granted requester.
  - oReqBank = bank; the bank's oBankBusy is set.
  - Next state IDLE.
- FINISH, count != ENTRIES: oErr set, bank stays free, no oReqDone; -> IDLE. The requester is not re-granted automatically and must re-raise iReq.
- Watchdog: TIMEOUT consecutive RUN cycles without iEngValid/iEngDone -> same error handling as a short run.
- iEngValid/iEngDone sampled outside RUN are ignored; this covers stale engine output after reset.
- iRelease[b]:
  - Clears oBankBusy[b] next cycle; releasing a free bank is a no-op.
  - Release and allocation in the same cycle affect different banks by construction.
  - A released bank is allocatable in the following cycle.
- Back-to-back: a new grant is possible in the cycle after FINISH, so jobs are spaced at least 1 idle cycle apart.
- iReq dropped before grant: the request is withdrawn with no side effects.
- Reset mid-job: returns immediately to reset values. The engine is not reset; its stale outputs are masked as above.
- Width rules: entry counter is clog2(ENTRIES+1) bits; watchdog is clog2(TIMEOUT+1) bits, saturating.

Decomposition:
- Package exp_sigma_pkg holds:
  - SIGMA_W=18, DATA_W=17, ADDR_W=6, BANK_W=1.
  - FSM state enum.
  - Default ENTRIES/TIMEOUT constants.
- Sub-module rr_arbiter:
  - Parameterised by NREQ.
  - Inputs: request vector, enable, advance-pointer strobe.
  - Outputs: one-hot grant and index.
  - Pointer state and reset are internal.

Test Plan:
- Single job: iReq[0]=1, sigma0=6554; engine model emits 64 valids then done -> oGrant=01, one oEngStart with oEngSigma=6554, 64 writes to addresses 0x00-0x3F, oReqDone=01, oReqBank=0, oBankBusy=01.
- Round-robin fairness: iReq=11 held, sigma0=6554, sigma1=13107, releasing banks after each job -> grants alternate 01,10,01,10; oEngSigma matches the granted requester each time.
- Bank exhaustion: two jobs without release -> oBankBusy=11 and a third request gets no grant. Pulse iRelease=01 -> grant occurs 1 cycle later and the job writes oWrAddr 0x00-0x3F.
- Short run: engine gives 63 valids then done -> oErr=1, no oReqDone, oBankBusy unchanged; the re-raised request then succeeds.
- Timeout with TIMEOUT=15: engine silent after start -> oErr=1 after 15 idle RUN cycles, FSM returns to IDLE, no writes.
- Reset mid-RUN after 20 valids: nRST low -> all outputs 0 asynchronously; stale iEngValid after reset produces no oWrEn.
